horner_seq_ctrl: RTL and testbench
==================================

Name: horner_seq_ctrl

Overview:
- Sequencer for the Horner polynomial evaluator: acc = c[d]; then for k = d-1 down to 0, acc = acc*x + c[k].
- Accepts one evaluation request (x plus runtime degree d) over a valid/ready handshake.
- Drives the select input of the 11-way registered coefficient mux (1-cycle latency) and issues the load and multiply-add strobes to the accumulator datapath.
- Presents result-valid to the consumer with backpressure.

Parameters:
- MAX_DEG, 10, highest supported degree (coefficients 0..MAX_DEG).
- SEL_W, 4, width of coeff_select; must satisfy 2^SEL_W > MAX_DEG.
- MAC_LAT, 3, cycles from a load/MAC strobe until the accumulator result is usable; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- GlobalReset  in  1  asynchronous, active-low reset.
- x_valid  in  1  request valid.
- x_ready  out  1  controller can accept a request.
- degree  in  SEL_W  polynomial degree for the request; sampled on accept.
- x_latch  out  1  one-cycle pulse: datapath captures x into its operand register.
- coeff_select  out  SEL_W  coefficient index to the mux; registered.
- acc_load  out  1  one-cycle pulse: acc <= mux coeff.
- mac_en  out  1  one-cycle pulse: acc <= acc*x + mux coeff.
- res_valid  out  1  accumulator holds final result.
- res_ready  in  1  consumer takes the result.
- busy  out  1  high in every state except IDLE.
- err_degree  out  1  one-cycle pulse: requested degree exceeded MAX_DEG and was clamped.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, GlobalReset=0) values:
  - state=IDLE, coeff_select=0, k=0, wait counter=0.
  - x_latch=0, acc_load=0, mac_en=0, res_valid=0, err_degree=0, busy=0.
  - x_ready=1 once reset is released.
- States:
  - IDLE: x_ready=1. On accept (x_valid & x_ready):
    - d_r <= min(degree, MAX_DEG); err_degree pulses if degree > MAX_DEG.
    - k <= d_r; coeff_select <= d_r; x_latch pulses; go to FETCH.
  - FETCH: exactly 1 cycle; covers the mux register latency. Go to ISSUE.
  - ISSUE: exactly 1 cycle.
    - If k == d_r, pulse acc_load; otherwise pulse mac_en.
    - If k != 0: k <= k-1 and coeff_select <= k-1 (prefetch).
    - Load the wait counter with MAC_LAT; go to WAIT.
  - WAIT: lasts exactly MAC_LAT cycles.
    - At expiry: if k was 0 at the last ISSUE, go to DONE; otherwise go to ISSUE.
    - The prefetched coefficient is stable at the mux output before the next ISSUE because MAC_LAT >= 1.
  - DONE: res_valid=1, held until res_ready=1. The transfer cycle returns to IDLE; res_valid=0 the next cycle.
- Timing (accept in cycle 0, L = MAC_LAT):
  - ISSUE cycles are 2 + j*(L+1), j = 0..d.
  - res_valid first high in cycle 2 + (d+1)*(L+1).
  - Exactly one acc_load and exactly d mac_en pulses per request.
- Strobe ordering: coeff_select sequence is d, d-1, ..., 0. acc_load and mac_en are never high together. x_latch fires only in the cycle after accept.
- Boundary conditions:
  - d=0: acc_load only, no mac_en.
  - x_valid while busy: ignored (x_ready=0); there is no queueing.
  - res_ready without res_valid: ignored.
  - A new request is never accepted in the same cycle as a result transfer; earliest accept is the cycle after.
  - degree change while busy: no effect, since d_r is already latched.
  - coeff_select after completion: holds 0 until the next accept.
  - Reset mid-operation: immediate return to reset values; no further strobes issue.
  - Datapath/mux reset is separate, so acc contents after reset are don't-care.

Test Plan:
- Single request, d=10, x_valid pulsed in cycle 0, MAC_LAT=3, res_ready=1 → x_latch in cycle 1; acc_load in cycle 2; mac_en in cycles 6,10,...,42; coeff_select stepping 10..0; res_valid in cycle 46 for one cycle; with a reference accumulator model and all coefficients=1, x=2 → result 2047.
- Single request, d=0 → acc_load in cycle 2, no mac_en, res_valid in cycle 6, coeff_select=0 throughout.
- Single request, degree=13 → err_degree pulses in cycle 1, evaluation runs as d=10, res_valid in cycle 46.
- Backpressure: res_ready held 0 for 5 cycles after res_valid, x_valid held 1 throughout → res_valid stays 1, x_ready stays 0, new accept occurs only the cycle after res_ready=1.
- Reset mid-run: GlobalReset=0 asserted in cycle 20 of a d=10 run → all outputs at reset values in that cycle without waiting for a clock edge; no strobes afterwards; next request evaluates correctly.
- MAC_LAT=1, d=3 → ISSUE cycles 2,4,6,8; res_valid in cycle 10; checker confirms coeff_select is stable one cycle before each ISSUE.

Source files
------------

// File: rtl/horner_seq_ctrl.sv
// -----------------------------------------------------------------------------
// horner_seq_ctrl
//
// Sequencer for a Horner polynomial evaluator. For one request (x, degree d)
// the datapath computes acc = c[d], then acc = acc*x + c[k] for k = d-1..0.
// This block drives the coefficient-mux select (the mux itself is registered,
// so a select change is visible one cycle later) and pulses the accumulator
// load / multiply-add strobes, spacing them MAC_LAT+1 cycles apart so each
// accumulator update has settled before the next one uses it.
//
// State walk: IDLE -> FETCH -> ISSUE -> WAIT(MAC_LAT) -> ISSUE ... -> DONE.
//
// Parameters:
//   MAX_DEG  highest supported degree (coefficients 0..MAX_DEG)
//   SEL_W    width of degree / coeff_select; 2**SEL_W must exceed MAX_DEG
//   MAC_LAT  accumulator latency in cycles, 1..15
//
// Ports:
//   clk           system clock, rising edge
//   GlobalReset   asynchronous active-low reset
//   x_valid/x_ready   request handshake (accepted only in IDLE)
//   degree        requested degree, sampled on accept, clamped to MAX_DEG
//   x_latch       1-cycle pulse: datapath captures x
//   coeff_select  registered coefficient index for the mux
//   acc_load      1-cycle pulse: acc <= coeff
//   mac_en        1-cycle pulse: acc <= acc*x + coeff
//   res_valid/res_ready  result handshake; result held under backpressure
//   busy          high in every state except IDLE
//   err_degree    1-cycle pulse: requested degree was clamped
//
// Every output comes straight from a flop.
// -----------------------------------------------------------------------------
module horner_seq_ctrl #(
  parameter int MAX_DEG = 10,
  parameter int SEL_W   = 4,
  parameter int MAC_LAT = 3
) (
  input  logic             clk,
  input  logic             GlobalReset,
  input  logic             x_valid,
  output logic             x_ready,
  input  logic [SEL_W-1:0] degree,
  output logic             x_latch,
  output logic [SEL_W-1:0] coeff_select,
  output logic             acc_load,
  output logic             mac_en,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy,
  output logic             err_degree
);

  // Wait counter must hold MAC_LAT itself.
  localparam int CNT_W = (MAC_LAT < 2) ? 1 : $clog2(MAC_LAT + 1);

  localparam logic [SEL_W-1:0] MAX_DEG_W = SEL_W'(MAX_DEG);
  localparam logic [CNT_W-1:0] LAT_W     = CNT_W'(MAC_LAT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_t             r_state;
  logic [SEL_W-1:0]   r_d;        // clamped degree of the current request
  logic [SEL_W-1:0]   r_k;        // index of the coefficient for the next ISSUE
  logic [SEL_W-1:0]   r_sel;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_last;     // k was 0 at the most recent ISSUE
  logic               r_x_ready;
  logic               r_x_latch;
  logic               r_acc_load;
  logic               r_mac_en;
  logic               r_res_valid;
  logic               r_busy;
  logic               r_err;

  // Next-state values
  state_t             w_state_nxt;
  logic [SEL_W-1:0]   w_d_nxt;
  logic [SEL_W-1:0]   w_k_nxt;
  logic [SEL_W-1:0]   w_sel_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_last_nxt;
  logic               w_x_ready_nxt;
  logic               w_x_latch_nxt;
  logic               w_acc_load_nxt;
  logic               w_mac_en_nxt;
  logic               w_res_valid_nxt;
  logic               w_busy_nxt;
  logic               w_err_nxt;

  // Helpers
  logic               w_accept;
  logic               w_deg_over;
  logic [SEL_W-1:0]   w_deg_clamped;
  logic               w_first;

  // r_x_ready is only ever high while in IDLE, so it doubles as the state
  // qualifier for an accept.
  assign w_accept      = x_valid && r_x_ready;
  assign w_deg_over    = (degree > MAX_DEG_W);
  assign w_deg_clamped = w_deg_over ? MAX_DEG_W : degree;

  // The first ISSUE of a request is the only one where k still equals d;
  // it loads the accumulator, every later one multiply-adds.
  assign w_first = (r_k == r_d);

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_state_nxt     = r_state;
    w_d_nxt         = r_d;
    w_k_nxt         = r_k;
    w_sel_nxt       = r_sel;
    w_cnt_nxt       = r_cnt;
    w_last_nxt      = r_last;
    w_x_latch_nxt   = 1'b0;
    w_acc_load_nxt  = 1'b0;
    w_mac_en_nxt    = 1'b0;
    w_res_valid_nxt = 1'b0;
    w_err_nxt       = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_d_nxt       = w_deg_clamped;
          w_k_nxt       = w_deg_clamped;
          w_sel_nxt     = w_deg_clamped;
          w_x_latch_nxt = 1'b1;
          w_err_nxt     = w_deg_over;
          w_state_nxt   = S_FETCH;
        end
      end

      // One cycle for the registered mux to present c[d].
      S_FETCH: begin
        w_state_nxt    = S_ISSUE;
        w_acc_load_nxt = w_first;
        w_mac_en_nxt   = !w_first;
      end

      // The strobe is already on the output this cycle. Prefetch the next
      // coefficient now; it has MAC_LAT (>= 1) cycles to reach the mux output.
      S_ISSUE: begin
        if (r_k != '0) begin
          w_k_nxt   = r_k - 1'b1;
          w_sel_nxt = r_k - 1'b1;
        end
        w_last_nxt  = (r_k == '0);
        w_cnt_nxt   = LAT_W;
        w_state_nxt = S_WAIT;
      end

      S_WAIT: begin
        if (r_cnt <= CNT_W'(1)) begin
          w_cnt_nxt = '0;
          if (r_last) begin
            w_state_nxt     = S_DONE;
            w_res_valid_nxt = 1'b1;
          end else begin
            w_state_nxt    = S_ISSUE;
            w_acc_load_nxt = w_first;
            w_mac_en_nxt   = !w_first;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end

      // Result held until taken; the transfer cycle itself still shows
      // x_ready=0, so a new accept can happen at the earliest one cycle later.
      S_DONE: begin
        if (res_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_res_valid_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_x_ready_nxt = (w_state_nxt == S_IDLE);
    w_busy_nxt    = (w_state_nxt != S_IDLE);
  end

  // ---------------------------------------------------------------------------
  // State register (all outputs are flops, updated from the next-state logic)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      r_state     <= S_IDLE;
      r_d         <= '0;
      r_k         <= '0;
      r_sel       <= '0;
      r_cnt       <= '0;
      r_last      <= 1'b0;
      // x_ready rises on the first clock edge after reset is released.
      r_x_ready   <= 1'b0;
      r_x_latch   <= 1'b0;
      r_acc_load  <= 1'b0;
      r_mac_en    <= 1'b0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments so all
      // flops sample the same pre-edge values regardless of statement order.
      r_state     <= w_state_nxt;
      r_d         <= w_d_nxt;
      r_k         <= w_k_nxt;
      r_sel       <= w_sel_nxt;
      r_cnt       <= w_cnt_nxt;
      r_last      <= w_last_nxt;
      r_x_ready   <= w_x_ready_nxt;
      r_x_latch   <= w_x_latch_nxt;
      r_acc_load  <= w_acc_load_nxt;
      r_mac_en    <= w_mac_en_nxt;
      r_res_valid <= w_res_valid_nxt;
      r_busy      <= w_busy_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign x_ready      = r_x_ready;
  assign x_latch      = r_x_latch;
  assign coeff_select = r_sel;
  assign acc_load     = r_acc_load;
  assign mac_en       = r_mac_en;
  assign res_valid    = r_res_valid;
  assign busy         = r_busy;
  assign err_degree   = r_err;

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_strobes_exclusive : assert property (
    @(posedge clk) disable iff (!GlobalReset) !(r_acc_load && r_mac_en));

  a_ready_not_busy : assert property (
    @(posedge clk) disable iff (!GlobalReset) !(r_x_ready && r_busy));

  a_sel_in_range : assert property (
    @(posedge clk) disable iff (!GlobalReset) (r_sel <= MAX_DEG_W));

endmodule

// File: tb/tb_horner_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_horner_seq_ctrl
//
// Two controllers (MAC_LAT=3 and MAC_LAT=1) share clock and reset. A small
// behavioural datapath (registered coefficient mux + accumulator) sits behind
// each so the final accumulator value can be compared with the polynomial
// evaluated directly as sum(c[k] * x^k). Control outputs are compared every
// cycle against a timeline derived from the request's degree and latency.
// Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_horner_seq_ctrl;

  localparam int SEL_W   = 4;
  localparam int MAX_DEG = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             GlobalReset;
  logic             x_valid      [2];
  logic             x_ready      [2];
  logic [SEL_W-1:0] degree       [2];
  logic             x_latch      [2];
  logic [SEL_W-1:0] coeff_select [2];
  logic             acc_load     [2];
  logic             mac_en       [2];
  logic             res_valid    [2];
  logic             res_ready    [2];
  logic             busy         [2];
  logic             err_degree   [2];

  horner_seq_ctrl #(.MAX_DEG(MAX_DEG), .SEL_W(SEL_W), .MAC_LAT(3)) u_dut_l3 (
    .clk          (clk),
    .GlobalReset  (GlobalReset),
    .x_valid      (x_valid[0]),
    .x_ready      (x_ready[0]),
    .degree       (degree[0]),
    .x_latch      (x_latch[0]),
    .coeff_select (coeff_select[0]),
    .acc_load     (acc_load[0]),
    .mac_en       (mac_en[0]),
    .res_valid    (res_valid[0]),
    .res_ready    (res_ready[0]),
    .busy         (busy[0]),
    .err_degree   (err_degree[0])
  );

  horner_seq_ctrl #(.MAX_DEG(MAX_DEG), .SEL_W(SEL_W), .MAC_LAT(1)) u_dut_l1 (
    .clk          (clk),
    .GlobalReset  (GlobalReset),
    .x_valid      (x_valid[1]),
    .x_ready      (x_ready[1]),
    .degree       (degree[1]),
    .x_latch      (x_latch[1]),
    .coeff_select (coeff_select[1]),
    .acc_load     (acc_load[1]),
    .mac_en       (mac_en[1]),
    .res_valid    (res_valid[1]),
    .res_ready    (res_ready[1]),
    .busy         (busy[1]),
    .err_degree   (err_degree[1])
  );

  // ---------------------------------------------------------------------------
  // Behavioural datapath: registered coefficient mux and accumulator
  // ---------------------------------------------------------------------------
  logic [63:0] coef  [MAX_DEG+1];
  logic [63:0] x_in  [2];
  logic [63:0] x_op  [2];
  logic [63:0] mux_q [2];
  logic [63:0] acc   [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      mux_q[i] <= (int'(coeff_select[i]) <= MAX_DEG) ? coef[coeff_select[i]] : 64'hDEAD;
      if (x_latch[i]) x_op[i] <= x_in[i];
      if (acc_load[i])    acc[i] <= mux_q[i];
      else if (mac_en[i]) acc[i] <= acc[i] * x_op[i] + mux_q[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Scoring
  // ---------------------------------------------------------------------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic int lat(input int inst);
    return (inst == 0) ? 3 : 1;
  endfunction

  function automatic int clamp_deg(input int deg);
    return (deg > MAX_DEG) ? MAX_DEG : deg;
  endfunction

  // Direct evaluation: sum of c[k] * x^k (mod 2^64).
  function automatic logic [63:0] poly(input int d, input logic [63:0] x);
    logic [63:0] sum = '0;
    logic [63:0] pw  = 64'd1;
    for (int k = 0; k <= d; k++) begin
      sum = sum + coef[k] * pw;
      pw  = pw * x;
    end
    return sum;
  endfunction

  // Observed vector: {x_ready, busy, x_latch, acc_load, mac_en, res_valid, err, sel}
  function automatic logic [10:0] obs(input int inst);
    return {x_ready[inst], busy[inst], x_latch[inst], acc_load[inst], mac_en[inst],
            res_valid[inst], err_degree[inst], coeff_select[inst]};
  endfunction

  // Expected vector in cycle c after an accept in cycle 0.
  // ISSUE j happens in cycle 2 + j*(L+1); the result appears L+1 cycles after
  // the last ISSUE and is held for bp extra cycles of backpressure.
  function automatic logic [10:0] exp_vec(input int c, input int deg, input int L, input int bp);
    int   d      = clamp_deg(deg);
    int   tdone  = 2 + (d + 1) * (L + 1);
    int   tx     = tdone + bp;
    bit   issue  = (c >= 2) && ((c - 2) % (L + 1) == 0) && ((c - 2) / (L + 1) <= d);
    int   j      = (c >= 2) ? (c - 2) / (L + 1) : 0;
    int   n_done = 0;
    int   sel;
    if (c >= 3) n_done = ((c - 3) / (L + 1) + 1 > d + 1) ? d + 1 : (c - 3) / (L + 1) + 1;
    sel = (d - n_done < 0) ? 0 : d - n_done;
    return {(c > tx), (c >= 1 && c <= tx), (c == 1), (issue && j == 0), (issue && j > 0),
            (c >= tdone && c <= tx), (c == 1 && deg > MAX_DEG), 4'(sel)};
  endfunction

  localparam logic [10:0] IDLE_VEC  = 11'h400;
  localparam logic [10:0] RESET_VEC = 11'h000;

  // ---------------------------------------------------------------------------
  // One request on instance inst, starting in the current (falling-edge) cycle.
  // bp   : cycles res_ready is held low once res_valid is up
  // hold : keep x_valid high through the run (and after it)
  // abort_at : assert reset in this cycle and stop (0 = never)
  // ---------------------------------------------------------------------------
  task automatic run_req(input string tag, input int inst, input int deg,
                         input logic [63:0] x, input int bp, input bit hold,
                         input logic [63:0] exp_res, input int exp_tdone,
                         input int abort_at);
    int L        = lat(inst);
    int d        = clamp_deg(deg);
    int tdone    = 2 + (d + 1) * (L + 1);
    int tend     = tdone + bp + 1;
    int first_rv = -1;

    check($sformatf("%s_ready_at_accept", tag), 64'(x_ready[inst]), 64'd1);
    x_in[inst]      = x;
    x_valid[inst]   = 1'b1;
    degree[inst]    = SEL_W'(deg);
    res_ready[inst] = 1'($urandom % 2);

    for (int c = 1; c <= tend; c++) begin
      @(negedge clk);
      check($sformatf("%s_cyc%0d", tag, c), 64'(obs(inst)), 64'(exp_vec(c, deg, L, bp)));
      if (res_valid[inst] && first_rv < 0) first_rv = c;
      if (c == tdone) check($sformatf("%s_result", tag), acc[inst], exp_res);

      if (c == abort_at) begin
        GlobalReset = 1'b0;
        #1;
        check($sformatf("%s_async_reset_i0", tag), 64'(obs(0)), 64'(RESET_VEC));
        check($sformatf("%s_async_reset_i1", tag), 64'(obs(1)), 64'(RESET_VEC));
        return;
      end

      // Inputs for this cycle; degree and res_ready wiggle to show they are
      // ignored while busy / while no result is pending.
      degree[inst] = SEL_W'($urandom % 16);
      if (c < tend) begin
        x_valid[inst]   = hold ? 1'b1 : 1'($urandom % 2);
        res_ready[inst] = (c < tdone) ? 1'($urandom % 2) : 1'(c >= tdone + bp);
      end else begin
        x_valid[inst]   = hold;
        res_ready[inst] = 1'b0;
      end
    end
    check($sformatf("%s_first_res_valid_cycle", tag), 64'(first_rv), 64'(exp_tdone));
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    int          inst;
    int          deg;
    logic [63:0] x;
    int          bp;
    bit          hold;
    int          exp_tdone;
    logic [63:0] exp_res;     // with all coefficients = 1
  } vec_t;

  vec_t vecs [8];

  initial begin
    // Worked by hand with c[k] = 1: result = 1 + x + ... + x^d.
    vecs[0] = '{inst: 0, deg: 10, x: 64'd2, bp: 0, hold: 1'b0, exp_tdone: 46, exp_res: 64'd2047};
    vecs[1] = '{inst: 0, deg: 0,  x: 64'd2, bp: 0, hold: 1'b0, exp_tdone: 6,  exp_res: 64'd1};
    vecs[2] = '{inst: 0, deg: 13, x: 64'd2, bp: 0, hold: 1'b0, exp_tdone: 46, exp_res: 64'd2047};
    vecs[3] = '{inst: 0, deg: 5,  x: 64'd3, bp: 5, hold: 1'b1, exp_tdone: 26, exp_res: 64'd364};
    vecs[4] = '{inst: 0, deg: 2,  x: 64'd3, bp: 0, hold: 1'b0, exp_tdone: 14, exp_res: 64'd13};
    vecs[5] = '{inst: 1, deg: 3,  x: 64'd2, bp: 0, hold: 1'b0, exp_tdone: 10, exp_res: 64'd15};
    vecs[6] = '{inst: 1, deg: 0,  x: 64'd5, bp: 0, hold: 1'b0, exp_tdone: 4,  exp_res: 64'd1};
    vecs[7] = '{inst: 1, deg: 15, x: 64'd1, bp: 2, hold: 1'b0, exp_tdone: 24, exp_res: 64'd11};

    GlobalReset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      x_valid[i] = 1'b0; degree[i] = '0; res_ready[i] = 1'b0;
      x_in[i] = '0; x_op[i] = '0; mux_q[i] = '0; acc[i] = '0;
    end
    for (int k = 0; k <= MAX_DEG; k++) coef[k] = 64'd1;

    // Reset values
    #1;
    check("reset_i0", 64'(obs(0)), 64'(RESET_VEC));
    check("reset_i1", 64'(obs(1)), 64'(RESET_VEC));
    repeat (3) @(negedge clk);
    GlobalReset = 1'b1;
    @(negedge clk);
    check("post_reset_idle_i0", 64'(obs(0)), 64'(IDLE_VEC));
    check("post_reset_idle_i1", 64'(obs(1)), 64'(IDLE_VEC));

    // Table-driven directed requests
    for (int v = 0; v < 8; v++) begin
      run_req($sformatf("vec%0d", v), vecs[v].inst, vecs[v].deg, vecs[v].x, vecs[v].bp,
              vecs[v].hold, vecs[v].exp_res, vecs[v].exp_tdone, 0);
    end

    // res_ready with no result pending: stays idle
    res_ready[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("stray_res_ready_%0d", c), 64'(obs(0)), 64'(IDLE_VEC));
    end
    res_ready[0] = 1'b0;

    // Randomized requests against the direct polynomial
    for (int k = 0; k <= MAX_DEG; k++) coef[k] = 64'($urandom % 256);
    for (int r = 0; r < 12; r++) begin
      int          inst = int'($urandom % 2);
      int          deg  = int'($urandom % 16);
      logic [63:0] x    = 64'($urandom % 256);
      int          bp   = int'($urandom % 4);
      int          d    = clamp_deg(deg);
      run_req($sformatf("rnd%0d", r), inst, deg, x, bp, 1'b0, poly(d, x),
              2 + (d + 1) * (lat(inst) + 1), 0);
    end

    // Reset in cycle 20 of a d=10 run, then a clean request
    begin
      logic [63:0] x = 64'($urandom % 256);
      run_req("abort", 0, 10, x, 0, 1'b0, poly(10, x), 46, 20);
    end
    x_valid[0] = 1'b0; res_ready[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("in_reset_i0_%0d", c), 64'(obs(0)), 64'(RESET_VEC));
    end
    GlobalReset = 1'b1;
    @(negedge clk);
    check("after_abort_idle", 64'(obs(0)), 64'(IDLE_VEC));
    begin
      logic [63:0] x = 64'($urandom % 256);
      run_req("post_abort", 0, 7, x, 1, 1'b0, poly(7, x), 2 + 8 * 4, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Every wait above is bounded by the cycle loop; this only guards against a
  // bench bug that stops the clock-driven loops from advancing.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

endmodule
